// File: rtl/ball_track_scheduler_pkg.sv
// Shared types and constants for the ball tracking scheduler.
// State encoding, accumulator widths and default frame geometry.
package ball_track_pkg;

   localparam int SUM_W          = 28;
   localparam int COUNT_W        = 19;
   localparam int DEF_H_ACTIVE   = 640;
   localparam int DEF_V_ACTIVE   = 480;
   localparam int DEF_MIN_PIXELS = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACCUM,
      S_CHECK,
      S_DIV_X,
      S_DIV_Y,
      S_PUB
   } state_e;

endpackage

// File: rtl/ball_track_scheduler_if.sv
// Bundle of timing, detector and centroid handshake signals.
// The scheduler takes the slave side; timing/game logic the master.
interface ball_track_scheduler_if #(
   parameter int CNT_W = 13
);
   logic             TRACK_EN;
   logic [CNT_W-1:0] VGA_H_CNT;
   logic [CNT_W-1:0] VGA_V_CNT;
   logic             PIX_HIT;
   logic             DET_ENABLE;
   logic [CNT_W-1:0] BALL_X;
   logic [CNT_W-1:0] BALL_Y;
   logic             BALL_VALID;
   logic             BALL_READY;
   logic             LOST;
   logic             OVERRUN;

   modport master (
      output TRACK_EN, VGA_H_CNT, VGA_V_CNT,
      output PIX_HIT, BALL_READY,
      input  DET_ENABLE, BALL_X, BALL_Y,
      input  BALL_VALID, LOST, OVERRUN
   );

   modport slave (
      input  TRACK_EN, VGA_H_CNT, VGA_V_CNT,
      input  PIX_HIT, BALL_READY,
      output DET_ENABLE, BALL_X, BALL_Y,
      output BALL_VALID, LOST, OVERRUN
   );
endinterface

// File: rtl/ball_track_scheduler_serial_divider.sv
// Restoring serial divider, one quotient bit per clock.
// The first bit is resolved on the start edge, so a run takes SUM_W cycles.
module serial_divider
   import ball_track_pkg::*;
#(
   parameter int Q_W = 13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [SUM_W-1:0]   dividend_i,
   input  logic [COUNT_W-1:0] divisor_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [Q_W-1:0]     quotient_o
);
   localparam logic [4:0] CNT_LAST = 5'(SUM_W - 1);

   logic [COUNT_W-1:0] div_q, rem_q, rem_d;
   logic [COUNT_W-1:0] div_sel, rem_sel;
   logic [SUM_W-1:0]   quo_q, quo_d, quo_sel;
   logic [COUNT_W:0]   trial, diff;
   logic [4:0]         cnt_q;
   logic               busy_q, done_q, load;

   assign load = start_i && !busy_q;

   // One restoring step on either fresh operands or the running state
   always_comb begin
      div_sel = load ? divisor_i : div_q;
      rem_sel = load ? '0 : rem_q;
      quo_sel = load ? dividend_i : quo_q;
      trial   = {rem_sel, quo_sel[SUM_W-1]};
      diff    = trial - {1'b0, div_sel};
      rem_d   = trial[COUNT_W-1:0];
      quo_d   = {quo_sel[SUM_W-2:0], 1'b0};
      if (trial >= {1'b0, div_sel}) begin
         rem_d    = diff[COUNT_W-1:0];
         quo_d[0] = 1'b1;
      end
   end

   // Iteration counter and busy/done sequencing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load) begin
            div_q  <= divisor_i;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= 5'd1;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == CNT_LAST) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign quotient_o = quo_q[Q_W-1:0];

endmodule

// File: rtl/ball_track_scheduler.sv
// Frame-level controller: gates detection, accumulates hit coordinates
// and publishes one centroid per frame over valid/ready.
module ball_track_scheduler
   import ball_track_pkg::*;
#(
   parameter int CNT_W       = 13,
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int MIN_PIXELS  = DEF_MIN_PIXELS,
   parameter int LOST_FRAMES = 4
) (
   input logic                   CLK,
   input logic                   RESET,
   ball_track_scheduler_if.slave bus
);
   localparam int MISS_W = $clog2(LOST_FRAMES + 1);
   localparam logic [MISS_W-1:0]  MISS_MAX = MISS_W'(LOST_FRAMES);
   localparam logic [CNT_W-1:0]   H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0]   V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [COUNT_W-1:0] MIN_CNT  = COUNT_W'(MIN_PIXELS);

   state_e             state_q;
   logic [SUM_W-1:0]   sum_x_q, sum_y_q, sum_x_d, sum_y_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [MISS_W-1:0]  miss_q;
   logic [CNT_W-1:0]   qx_q, ball_x_q, ball_y_q;
   logic               det_en_q, valid_q, overrun_q;
   logic               sof, eof, hit;
   logic               div_start, div_busy, div_done;
   logic [SUM_W-1:0]   div_dividend;
   logic [CNT_W-1:0]   div_quo;

   assign sof = (bus.VGA_H_CNT == '0) && (bus.VGA_V_CNT == '0);
   assign eof = (bus.VGA_H_CNT == '0) && (bus.VGA_V_CNT == V_ACT);
   assign hit = bus.PIX_HIT && (bus.VGA_H_CNT < H_ACT)
             && (bus.VGA_V_CNT < V_ACT);

   // Divisor is count, never zero here because MIN_PIXELS >= 1
   assign div_start = bus.TRACK_EN && !div_busy
                   && (((state_q == S_CHECK) && (count_q >= MIN_CNT))
                   || ((state_q == S_DIV_X) && div_done));
   assign div_dividend = (state_q == S_CHECK) ? sum_x_q : sum_y_q;

   // Next accumulator values; count saturates, sums are wide enough
   always_comb begin
      sum_x_d = sum_x_q + {{(SUM_W-CNT_W){1'b0}}, bus.VGA_H_CNT};
      sum_y_d = sum_y_q + {{(SUM_W-CNT_W){1'b0}}, bus.VGA_V_CNT};
      count_d = (&count_q) ? count_q : count_q + 1'b1;
   end

   serial_divider #(.Q_W(CNT_W)) u_div (
      .clk        (CLK),
      .rst        (RESET),
      .start_i    (div_start),
      .dividend_i (div_dividend),
      .divisor_i  (count_q),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quotient_o (div_quo)
   );

   // Frame sequencing, accumulation, publish handshake and miss tracking
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         sum_x_q   <= '0;
         sum_y_q   <= '0;
         count_q   <= '0;
         miss_q    <= '0;
         qx_q      <= '0;
         ball_x_q  <= '0;
         ball_y_q  <= '0;
         det_en_q  <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (valid_q && bus.BALL_READY) valid_q <= 1'b0;
         if (!bus.TRACK_EN) begin
            state_q  <= S_IDLE;
            det_en_q <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: state_q <= S_WAIT;
               S_WAIT: begin
                  if (sof) begin
                     sum_x_q  <= '0;
                     sum_y_q  <= '0;
                     count_q  <= '0;
                     det_en_q <= 1'b1;
                     state_q  <= S_ACCUM;
                  end
               end
               S_ACCUM: begin
                  if (hit) begin
                     sum_x_q <= sum_x_d;
                     sum_y_q <= sum_y_d;
                     count_q <= count_d;
                  end
                  if (eof) begin
                     det_en_q <= 1'b0;
                     state_q  <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (count_q < MIN_CNT) begin
                     if (miss_q != MISS_MAX) miss_q <= miss_q + 1'b1;
                     state_q <= S_WAIT;
                  end else begin
                     state_q <= S_DIV_X;
                  end
               end
               S_DIV_X: begin
                  if (div_done) begin
                     qx_q    <= div_quo;
                     state_q <= S_DIV_Y;
                  end
               end
               S_DIV_Y: if (div_done) state_q <= S_PUB;
               S_PUB: begin
                  ball_x_q  <= qx_q;
                  ball_y_q  <= div_quo;
                  overrun_q <= valid_q && !bus.BALL_READY;
                  valid_q   <= 1'b1;
                  miss_q    <= '0;
                  state_q   <= S_WAIT;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.DET_ENABLE = det_en_q;
   assign bus.BALL_X     = ball_x_q;
   assign bus.BALL_Y     = ball_y_q;
   assign bus.BALL_VALID = valid_q;
   assign bus.LOST       = (miss_q == MISS_MAX);
   assign bus.OVERRUN    = overrun_q;

endmodule

// File: tb/tb_ball_track_scheduler.sv
// Bench for ball_track_scheduler: random hit blobs per frame,
// centroid/miss expectations from a frame-level reference model.
module tb_ball_track_scheduler;
   import ball_track_pkg::*;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   ball_track_scheduler_if #(.CNT_W(13)) bus ();

   ball_track_scheduler #(
      .CNT_W(13), .H_ACTIVE(640), .V_ACTIVE(480),
      .MIN_PIXELS(16), .LOST_FRAMES(4)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int m_miss = 0;
   int hq_x[$];
   int hq_y[$];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input int h, input int v, input bit hit);
      bus.VGA_H_CNT = 13'(h);
      bus.VGA_V_CNT = 13'(v);
      bus.PIX_HIT   = hit;
      tick();
   endtask

   task automatic park();
      bus.VGA_H_CNT = 13'd700;
      bus.VGA_V_CNT = 13'd490;
      bus.PIX_HIT   = 1'b0;
   endtask

   task automatic gen_blob(input int n, input int cx, input int cy);
      for (int i = 0; i < n; i++) begin
         hq_x.push_back(cx + int'($urandom_range(0, 16)) - 8);
         hq_y.push_back(cy + int'($urandom_range(0, 16)) - 8);
      end
   endtask

   task automatic add_stray(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            hq_x.push_back(int'($urandom_range(640, 1000)));
            hq_y.push_back(int'($urandom_range(0, 479)));
         end else begin
            hq_x.push_back(int'($urandom_range(1, 639)));
            hq_y.push_back(int'($urandom_range(480, 600)));
         end
      end
   endtask

   task automatic play_frame(output int cnt, output int ex, output int ey);
      longint sx, sy;
      sx = 0;
      sy = 0;
      cnt = 0;
      drive(0, 0, 0);
      n_vec++;
      if (bus.DET_ENABLE !== 1'b1) begin
         n_err++;
         $display("FAIL det_en_after_sof: got %b want 1", bus.DET_ENABLE);
      end
      foreach (hq_x[i]) begin
         if (hq_x[i] < 640 && hq_y[i] < 480) begin
            cnt++;
            sx += hq_x[i];
            sy += hq_y[i];
         end
         drive(hq_x[i], hq_y[i], 1);
         if ($urandom_range(0, 3) == 0)
            drive(int'($urandom_range(1, 639)), int'($urandom_range(0, 479)), 0);
      end
      drive(0, 480, 0);
      park();
      hq_x.delete();
      hq_y.delete();
      ex = (cnt > 0) ? int'(sx / cnt) : 0;
      ey = (cnt > 0) ? int'(sy / cnt) : 0;
   endtask

   task automatic await_pub(input int cnt, input int ex, input int ey);
      bit good;
      bit lost_before;
      bit lost57;
      int first, gx, gy, vcnt;
      good = (cnt >= 16);
      lost_before = (m_miss == 4);
      lost57 = 1'b0;
      first = -1;
      gx = 0;
      gy = 0;
      vcnt = 0;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (k == 57) lost57 = bus.LOST;
         if (bus.BALL_VALID === 1'b1) begin
            vcnt++;
            if (first < 0) begin
               first = k;
               gx = int'(bus.BALL_X);
               gy = int'(bus.BALL_Y);
            end
         end
      end
      if (good) begin
         n_vec += 5;
         if (first != 58) begin
            n_err++;
            $display("FAIL latency: got %0d want 58", first);
         end
         if (gx != ex) begin
            n_err++;
            $display("FAIL ball_x: got %0d want %0d", gx, ex);
         end
         if (gy != ey) begin
            n_err++;
            $display("FAIL ball_y: got %0d want %0d", gy, ey);
         end
         if (vcnt != 1) begin
            n_err++;
            $display("FAIL valid_cycles: got %0d want 1", vcnt);
         end
         if (lost57 !== lost_before) begin
            n_err++;
            $display("FAIL lost_pre_pub: got %b want %b", lost57, lost_before);
         end
         m_miss = 0;
      end else begin
         n_vec++;
         if (vcnt != 0) begin
            n_err++;
            $display("FAIL no_publish: got %0d valid cycles want 0", vcnt);
         end
         if (m_miss < 4) m_miss++;
      end
      n_vec++;
      if (bus.LOST !== (m_miss == 4)) begin
         n_err++;
         $display("FAIL lost: got %b want %b", bus.LOST, m_miss == 4);
      end
   endtask

   task automatic check_all_zero(input string tag);
      n_vec++;
      if (bus.DET_ENABLE !== 1'b0 || bus.BALL_VALID !== 1'b0 ||
          bus.BALL_X !== 13'd0 || bus.BALL_Y !== 13'd0 ||
          bus.LOST !== 1'b0 || bus.OVERRUN !== 1'b0) begin
         n_err++;
         $display("FAIL %s: got en=%b v=%b x=%0d y=%0d lost=%b ov=%b want all 0",
                  tag, bus.DET_ENABLE, bus.BALL_VALID, bus.BALL_X,
                  bus.BALL_Y, bus.LOST, bus.OVERRUN);
      end
   endtask

   task automatic test_reset();
      check_all_zero("reset_state");
      RESET = 1'b0;
      tick();
      tick();
      check_all_zero("idle_after_release");
   endtask

   task automatic test_basic();
      int c, ex, ey;
      bus.TRACK_EN = 1'b1;
      bus.BALL_READY = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 16; i++) begin
         hq_x.push_back(100 + i % 4);
         hq_y.push_back(200 + i / 4);
      end
      play_frame(c, ex, ey);
      n_vec++;
      if (ex != 101 || ey != 201) begin
         n_err++;
         $display("FAIL model_block: got %0d,%0d want 101,201", ex, ey);
      end
      await_pub(c, 101, 201);
   endtask

   task automatic test_random();
      int c, ex, ey;
      for (int f = 0; f < 6; f++) begin
         gen_blob(int'($urandom_range(16, 60)),
                  int'($urandom_range(20, 620)),
                  int'($urandom_range(20, 460)));
         add_stray(int'($urandom_range(0, 12)));
         play_frame(c, ex, ey);
         await_pub(c, ex, ey);
      end
   endtask

   task automatic test_lost();
      int c, ex, ey;
      for (int f = 0; f < 5; f++) begin
         gen_blob(10, int'($urandom_range(50, 590)), int'($urandom_range(50, 430)));
         play_frame(c, ex, ey);
         await_pub(c, ex, ey);
      end
      gen_blob(40, int'($urandom_range(50, 590)), int'($urandom_range(50, 430)));
      play_frame(c, ex, ey);
      await_pub(c, ex, ey);
   endtask

   task automatic test_overrun();
      int c, ax, ay, bx, by, cx, cy, ov;
      bit held, early_ok;
      bus.BALL_READY = 1'b0;
      gen_blob(20, 300, 100);
      play_frame(c, ax, ay);
      repeat (70) tick();
      m_miss = 0;
      n_vec++;
      if (bus.BALL_VALID !== 1'b1 || int'(bus.BALL_X) != ax || int'(bus.BALL_Y) != ay) begin
         n_err++;
         $display("FAIL hold_a: got v=%b %0d,%0d want 1 %0d,%0d",
                  bus.BALL_VALID, bus.BALL_X, bus.BALL_Y, ax, ay);
      end
      gen_blob(25, 500, 400);
      play_frame(c, bx, by);
      ov = 0;
      held = 1'b1;
      early_ok = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (bus.OVERRUN === 1'b1) ov++;
         if (bus.BALL_VALID !== 1'b1) held = 1'b0;
         if (k < 58 && (int'(bus.BALL_X) != ax || int'(bus.BALL_Y) != ay))
            early_ok = 1'b0;
      end
      n_vec += 4;
      if (ov != 1) begin
         n_err++;
         $display("FAIL overrun_pulses: got %0d want 1", ov);
      end
      if (!held) begin
         n_err++;
         $display("FAIL valid_held: got dropped want held");
      end
      if (!early_ok) begin
         n_err++;
         $display("FAIL data_stable: got change before pub want stable");
      end
      if (int'(bus.BALL_X) != bx || int'(bus.BALL_Y) != by) begin
         n_err++;
         $display("FAIL overwrite: got %0d,%0d want %0d,%0d",
                  bus.BALL_X, bus.BALL_Y, bx, by);
      end
      gen_blob(30, 60, 60);
      play_frame(c, cx, cy);
      repeat (57) tick();
      bus.BALL_READY = 1'b1;
      tick();
      n_vec++;
      if (bus.BALL_VALID !== 1'b1 || bus.OVERRUN !== 1'b0 ||
          int'(bus.BALL_X) != cx || int'(bus.BALL_Y) != cy) begin
         n_err++;
         $display("FAIL pub_with_ready: got v=%b ov=%b %0d,%0d want 1 0 %0d,%0d",
                  bus.BALL_VALID, bus.OVERRUN, bus.BALL_X, bus.BALL_Y, cx, cy);
      end
      tick();
      n_vec++;
      if (bus.BALL_VALID !== 1'b0) begin
         n_err++;
         $display("FAIL consume: got v=%b want 0", bus.BALL_VALID);
      end
   endtask

   task automatic test_track_drop();
      int c, ex, ey, vcnt;
      drive(0, 0, 0);
      for (int i = 0; i < 12; i++) drive(150 + i % 4, 100 + i / 4, 1);
      bus.TRACK_EN = 1'b0;
      drive(50, 300, 1);
      n_vec++;
      if (bus.DET_ENABLE !== 1'b0) begin
         n_err++;
         $display("FAIL drop_det_en: got %b want 0", bus.DET_ENABLE);
      end
      bus.TRACK_EN = 1'b1;
      for (int i = 0; i < 20; i++) drive(120 + i, 350, 1);
      drive(0, 480, 0);
      park();
      n_vec++;
      if (bus.DET_ENABLE !== 1'b0) begin
         n_err++;
         $display("FAIL resume_det_en: got %b want 0", bus.DET_ENABLE);
      end
      vcnt = 0;
      for (int k = 0; k < 70; k++) begin
         tick();
         if (bus.BALL_VALID === 1'b1) vcnt++;
      end
      n_vec++;
      if (vcnt != 0) begin
         n_err++;
         $display("FAIL aborted_frame: got %0d valid cycles want 0", vcnt);
      end
      gen_blob(24, 400, 240);
      play_frame(c, ex, ey);
      await_pub(c, ex, ey);
   endtask

   task automatic test_out_of_area();
      int c, ex, ey;
      for (int i = 0; i < 20; i++) begin
         hq_x.push_back(700);
         hq_y.push_back(int'($urandom_range(0, 479)));
         hq_x.push_back(int'($urandom_range(1, 639)));
         hq_y.push_back(500);
      end
      play_frame(c, ex, ey);
      await_pub(c, ex, ey);
   endtask

   task automatic test_reset_div();
      int c, ex, ey, vcnt;
      bus.BALL_READY = 1'b0;
      gen_blob(20, 200, 300);
      play_frame(c, ex, ey);
      repeat (70) tick();
      n_vec++;
      if (bus.BALL_VALID !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset_valid: got %b want 1", bus.BALL_VALID);
      end
      gen_blob(20, 450, 150);
      play_frame(c, ex, ey);
      repeat (40) tick();
      #3 RESET = 1'b1;
      #1;
      check_all_zero("reset_in_div_y");
      tick();
      RESET = 1'b0;
      m_miss = 0;
      vcnt = 0;
      for (int k = 0; k < 80; k++) begin
         tick();
         if (bus.BALL_VALID === 1'b1) vcnt++;
      end
      n_vec++;
      if (vcnt != 0 || bus.BALL_X !== 13'd0 || bus.BALL_Y !== 13'd0) begin
         n_err++;
         $display("FAIL stale_centroid: got %0d valid x=%0d y=%0d want 0 0 0",
                  vcnt, bus.BALL_X, bus.BALL_Y);
      end
      bus.BALL_READY = 1'b1;
   endtask

   initial begin
      RESET = 1'b1;
      bus.TRACK_EN = 1'b0;
      bus.BALL_READY = 1'b1;
      park();
      repeat (3) tick();
      test_reset();
      test_basic();
      test_random();
      test_lost();
      test_overrun();
      test_track_drop();
      test_out_of_area();
      test_reset_div();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
